mem_port_arbiter: RTL and testbench

Shares one memory port (unified instr/data RAM) between the fetch stage instruction interface and the LSU data interface. Implements the codebase req/gnt/rvalid handshake on all three sides. Uses data-first priority with a starvation guard for fetch, and tracks outstanding transactions so each response returns to the requester that issued it. Sits between fetch/lsu and the single RAM model, replacing the separate instr_ram/data_ram paths.

---
 rtl/mem_port_arbiter_if.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port arbiter: fetch, LSU and RAM sides.
// The slave modport is the arbiter's view; master is the environment's.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req_in;
  logic [ADDR_W-1:0] instr_addr_in;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;

  logic                instr_unused_pad;

  logic                data_req_in;
  logic [ADDR_W-1:0]   data_add_in;
  logic                data_we_in;
  logic [DATA_W/8-1:0] data_be_in;
  logic [DATA_W-1:0]   data_wdata_in;
  logic                data_gnt_o;
  logic                data_rvalid_o;
  logic [DATA_W-1:0]   data_rdata_o;

  logic                mem_req_o;
  logic [ADDR_W-1:0]   mem_add_o;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_gnt_in;
  logic                mem_rvalid_in;
  logic [DATA_W-1:0]   mem_rdata_in;

  logic err_o;

  modport slave (
    input  instr_req_in, instr_addr_in,
    input  data_req_in, data_add_in,
    input  data_we_in, data_be_in,
    input  data_wdata_in,
    input  mem_gnt_in, mem_rvalid_in,
    input  mem_rdata_in,
    output instr_gnt_o, instr_rvalid_o,
    output instr_rdata_o,
    output data_gnt_o, data_rvalid_o,
    output data_rdata_o,
    output mem_req_o, mem_add_o,
    output mem_we_o, mem_be_o,
    output mem_wdata_o, err_o
  );

  modport master (
    output instr_req_in, instr_addr_in,
    output data_req_in, data_add_in,
    output data_we_in, data_be_in,
    output data_wdata_in,
    output mem_gnt_in, mem_rvalid_in,
    output mem_rdata_in,
    input  instr_gnt_o, instr_rvalid_o,
    input  instr_rdata_o,
    input  data_gnt_o, data_rvalid_o,
    input  data_rdata_o,
    input  mem_req_o, mem_add_o,
    input  mem_we_o, mem_be_o,
    input  mem_wdata_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and LSU with data-first priority,
// a fetch starvation guard and in-order response routing.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input logic req,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_I,
    HOLD_D
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] src_q, src_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       err_q, err_d;

  logic full, empty, starve_pri;
  logic sel_i, sel_d, acc, acc_i;
  logic push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    return PW'(p + 1'b1);
  endfunction

  always_comb begin
    full  = (cnt_q == CW'(MAX_OUTSTANDING));
    empty = (cnt_q == '0);
    starve_pri = (starve_q == SW'(STARVE_LIMIT))
               & bus.instr_req_in;

    sel_i = 1'b0;
    sel_d = 1'b0;
    if (reset && !full) begin
      unique case (state_q)
        IDLE: begin
          if (bus.data_req_in && !starve_pri)
            sel_d = 1'b1;
          else if (bus.instr_req_in)
            sel_i = 1'b1;
        end
        HOLD_I:  sel_i = bus.instr_req_in;
        HOLD_D:  sel_d = bus.data_req_in;
        default: ;
      endcase
    end

    bus.mem_req_o   = sel_i | sel_d;
    bus.mem_add_o   = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_wdata_o = '0;
    unique case (1'b1)
      sel_i: begin
        bus.mem_add_o = bus.instr_addr_in;
        bus.mem_be_o  = {BE_W{1'b1}};
      end
      sel_d: begin
        bus.mem_add_o   = bus.data_add_in;
        bus.mem_we_o    = bus.data_we_in;
        bus.mem_be_o    = bus.data_be_in;
        bus.mem_wdata_o = bus.data_wdata_in;
      end
      default: ;
    endcase

    acc   = bus.mem_req_o & bus.mem_gnt_in;
    acc_i = acc & sel_i;
    bus.instr_gnt_o = acc_i;
    bus.data_gnt_o  = acc & sel_d;

    // Empty FIFO blocks the pop, so reset also silences rvalid.
    push = acc;
    pop  = bus.mem_rvalid_in & ~empty;
    head = src_q[rptr_q];
    bus.instr_rvalid_o = pop & ~head;
    bus.data_rvalid_o  = pop & head;
    bus.instr_rdata_o  = bus.mem_rdata_in;
    bus.data_rdata_o   = bus.mem_rdata_in;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sel_i && !bus.mem_gnt_in)
          state_d = HOLD_I;
        else if (sel_d && !bus.mem_gnt_in)
          state_d = HOLD_D;
      end
      HOLD_I: begin
        if (acc || (!full && !bus.instr_req_in))
          state_d = IDLE;
      end
      HOLD_D: begin
        if (acc || (!full && !bus.data_req_in))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    src_d  = src_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      src_d[wptr_q] = sel_d;
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);

    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = CW'(cnt_q + 1'b1);
      2'b01:   cnt_d = CW'(cnt_q - 1'b1);
      default: ;
    endcase

    starve_d = starve_q;
    if (!bus.instr_req_in || acc_i)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = SW'(starve_q + 1'b1);

    err_d = err_q | (bus.mem_rvalid_in & empty);
  end

  assign bus.err_o = err_q;

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      src_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: table sequence plus
// starvation and reset-with-outstanding corner cases.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT(4)
  ) dut (
    .req(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        mg;
    logic        mrv;
    logic [31:0] mrd;
    logic        eig;
    logic        edg;
    logic        eirv;
    logic        edrv;
    logic        emreq;
    logic [31:0] emaddr;
    logic        emwe;
    logic [3:0]  embe;
    logic [31:0] emwd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(
    input logic [31:0] ireq, iaddr, dreq, daddr,
    input logic [31:0] dwe, dbe, dwd, mg, mrv, mrd,
    input logic [31:0] eig, edg, eirv, edrv, emreq,
    input logic [31:0] emaddr, emwe, embe, emwd
  );
    vec_t v;
    v.ireq = ireq[0];   v.iaddr = iaddr;
    v.dreq = dreq[0];   v.daddr = daddr;
    v.dwe = dwe[0];     v.dbe = dbe[3:0];
    v.dwd = dwd;        v.mg = mg[0];
    v.mrv = mrv[0];     v.mrd = mrd;
    v.eig = eig[0];     v.edg = edg[0];
    v.eirv = eirv[0];   v.edrv = edrv[0];
    v.emreq = emreq[0]; v.emaddr = emaddr;
    v.emwe = emwe[0];   v.embe = embe[3:0];
    v.emwd = emwd;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.instr_req_in  = v.ireq;
    bus.instr_addr_in = v.iaddr;
    bus.data_req_in   = v.dreq;
    bus.data_add_in   = v.daddr;
    bus.data_we_in    = v.dwe;
    bus.data_be_in    = v.dbe;
    bus.data_wdata_in = v.dwd;
    bus.mem_gnt_in    = v.mg;
    bus.mem_rvalid_in = v.mrv;
    bus.mem_rdata_in  = v.mrd;
  endtask

  task automatic idle_in();
    drive(mk(0,0,0,0,0,0,0,0,0,0,
             0,0,0,0,0,0,0,0,0));
  endtask

  task automatic step_req(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic [31:0] da,
    input logic dwe, input logic mg,
    input logic mrv, input logic [31:0] mrd
  );
    @(posedge clk);
    #1;
    bus.instr_req_in  = ir;
    bus.instr_addr_in = ia;
    bus.data_req_in   = dr;
    bus.data_add_in   = da;
    bus.data_we_in    = dwe;
    bus.data_be_in    = 4'hF;
    bus.data_wdata_in = 32'h0;
    bus.mem_gnt_in    = mg;
    bus.mem_rvalid_in = mrv;
    bus.mem_rdata_in  = mrd;
    #3;
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,0,0,0,0,0,0,0,
                  0,0,0,0,0,0,0,0,0);
    vecs[1]  = mk(1,'h0,0,0,0,0,0,1,0,0,
                  1,0,0,0,1,'h0,0,'hF,0);
    vecs[2]  = mk(1,'h4,0,0,0,0,0,1,1,'hA0,
                  1,0,1,0,1,'h4,0,'hF,0);
    vecs[3]  = mk(1,'h8,0,0,0,0,0,1,1,'hA4,
                  1,0,1,0,1,'h8,0,'hF,0);
    vecs[4]  = mk(0,0,0,0,0,0,0,0,1,'hA8,
                  0,0,1,0,0,0,0,0,0);
    vecs[5]  = mk(0,0,1,'h100,1,'h3,'hDEADBEEF,1,0,0,
                  0,1,0,0,1,'h100,1,'h3,'hDEADBEEF);
    vecs[6]  = mk(0,0,0,0,0,0,0,0,1,'h55,
                  0,0,0,1,0,0,0,0,0);
    vecs[7]  = mk(1,'h20,0,0,0,0,0,0,0,0,
                  0,0,0,0,1,'h20,0,'hF,0);
    vecs[8]  = mk(1,'h20,1,'h40,0,'hF,0,0,0,0,
                  0,0,0,0,1,'h20,0,'hF,0);
    vecs[9]  = mk(1,'h20,1,'h40,0,'hF,0,0,0,0,
                  0,0,0,0,1,'h20,0,'hF,0);
    vecs[10] = mk(1,'h20,1,'h40,0,'hF,0,1,0,0,
                  1,0,0,0,1,'h20,0,'hF,0);
    vecs[11] = mk(0,0,1,'h40,0,'hF,0,1,0,0,
                  0,1,0,0,1,'h40,0,'hF,0);
    vecs[12] = mk(1,'h24,1,'h44,0,'hF,0,1,0,0,
                  0,0,0,0,0,0,0,0,0);
    vecs[13] = mk(1,'h24,1,'h44,0,'hF,0,1,1,'h11,
                  0,0,1,0,0,0,0,0,0);
    vecs[14] = mk(1,'h24,1,'h44,0,'hF,0,1,1,'h22,
                  0,1,0,1,1,'h44,0,'hF,0);
    vecs[15] = mk(1,'h24,0,0,0,0,0,1,1,'h33,
                  1,0,0,1,1,'h24,0,'hF,0);
    vecs[16] = mk(0,0,0,0,0,0,0,0,1,'h44,
                  0,0,1,0,0,0,0,0,0);
    vecs[17] = mk(0,0,0,0,0,0,0,0,0,0,
                  0,0,0,0,0,0,0,0,0);

    // Reset with a live data request: outputs must stay quiet.
    rst_n = 1'b0;
    idle_in();
    bus.data_req_in = 1'b1;
    bus.data_we_in  = 1'b1;
    bus.mem_gnt_in  = 1'b1;
    #3;
    chk("rst.mreq", 32'(bus.mem_req_o), 0);
    chk("rst.mwe", 32'(bus.mem_we_o), 0);
    chk("rst.dgt", 32'(bus.data_gnt_o), 0);
    chk("rst.err", 32'(bus.err_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_in();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      #3;
      chk($sformatf("v%0d.igt", i),
          32'(bus.instr_gnt_o), 32'(vecs[i].eig));
      chk($sformatf("v%0d.dgt", i),
          32'(bus.data_gnt_o), 32'(vecs[i].edg));
      chk($sformatf("v%0d.irv", i),
          32'(bus.instr_rvalid_o), 32'(vecs[i].eirv));
      chk($sformatf("v%0d.drv", i),
          32'(bus.data_rvalid_o), 32'(vecs[i].edrv));
      chk($sformatf("v%0d.mreq", i),
          32'(bus.mem_req_o), 32'(vecs[i].emreq));
      chk($sformatf("v%0d.maddr", i),
          bus.mem_add_o, vecs[i].emaddr);
      chk($sformatf("v%0d.mwe", i),
          32'(bus.mem_we_o), 32'(vecs[i].emwe));
      chk($sformatf("v%0d.mbe", i),
          32'(bus.mem_be_o), 32'(vecs[i].embe));
      chk($sformatf("v%0d.mwd", i),
          bus.mem_wdata_o, vecs[i].emwd);
      chk($sformatf("v%0d.err", i),
          32'(bus.err_o), 0);
      if (vecs[i].eirv)
        chk($sformatf("v%0d.irdata", i),
            bus.instr_rdata_o, vecs[i].mrd);
      if (vecs[i].edrv)
        chk($sformatf("v%0d.drdata", i),
            bus.data_rdata_o, vecs[i].mrd);
    end

    // Both requesting: four data grants, then one fetch grant.
    begin
      logic prev_acc, prev_i;
      prev_acc = 1'b0;
      prev_i   = 1'b0;
      for (int i = 0; i < 10; i++) begin
        logic ei;
        ei = ((i % 5) == 4);
        step_req(1, 32'h200, 1, 32'h300, 0,
                 1, prev_acc, 32'(i));
        chk($sformatf("st%0d.igt", i),
            32'(bus.instr_gnt_o), 32'(ei));
        chk($sformatf("st%0d.dgt", i),
            32'(bus.data_gnt_o), 32'(!ei));
        chk($sformatf("st%0d.irv", i),
            32'(bus.instr_rvalid_o),
            32'(prev_acc & prev_i));
        chk($sformatf("st%0d.drv", i),
            32'(bus.data_rvalid_o),
            32'(prev_acc & ~prev_i));
        prev_acc = 1'b1;
        prev_i   = ei;
      end
      step_req(0, 0, 0, 0, 0, 0, 1, 32'h99);
      chk("st.drain.irv", 32'(bus.instr_rvalid_o), 1);
      chk("st.drain.drv", 32'(bus.data_rvalid_o), 0);
    end

    // Two outstanding, then reset drops them.
    step_req(1, 32'h50, 0, 0, 0, 1, 0, 0);
    chk("rs.igt", 32'(bus.instr_gnt_o), 1);
    step_req(0, 0, 1, 32'h60, 1, 1, 0, 0);
    chk("rs.dgt", 32'(bus.data_gnt_o), 1);
    step_req(1, 32'h54, 1, 32'h64, 1, 1, 0, 0);
    chk("rs.full.mreq", 32'(bus.mem_req_o), 0);
    chk("rs.full.igt", 32'(bus.instr_gnt_o), 0);
    rst_n = 1'b0;
    bus.mem_rvalid_in = 1'b1;
    #1;
    chk("rs.low.mreq", 32'(bus.mem_req_o), 0);
    chk("rs.low.mwe", 32'(bus.mem_we_o), 0);
    chk("rs.low.igt", 32'(bus.instr_gnt_o), 0);
    chk("rs.low.dgt", 32'(bus.data_gnt_o), 0);
    chk("rs.low.irv", 32'(bus.instr_rvalid_o), 0);
    chk("rs.low.drv", 32'(bus.data_rvalid_o), 0);
    chk("rs.low.err", 32'(bus.err_o), 0);
    @(posedge clk);
    #1;
    idle_in();
    rst_n = 1'b1;
    bus.mem_rvalid_in = 1'b1;
    #3;
    chk("rs.late.irv", 32'(bus.instr_rvalid_o), 0);
    chk("rs.late.drv", 32'(bus.data_rvalid_o), 0);
    chk("rs.late.err0", 32'(bus.err_o), 0);
    step_req(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rs.err.set", 32'(bus.err_o), 1);
    step_req(1, 32'h70, 0, 0, 0, 1, 0, 0);
    chk("rs.err.sticky", 32'(bus.err_o), 1);
    chk("rs.resume.igt", 32'(bus.instr_gnt_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
